// File: rtl/ex_div.sv
// ex_div: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts one operation from ex, stalls the pipeline while it iterates,
// then returns a single registered write-back (rd, data, wen).
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_wen_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;       // op[2] is always 1 once accepted
  logic [DATA_W-1:0] dvd_q, dvs_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] quot, rem;
  logic [DATA_W-1:0] result_q;

  logic              accept, signed_op, is_rem, div_zero, ovf, last;
  logic              neg_q, neg_r, ge;
  logic [DATA_W-1:0] dvd_abs, dvs_abs, special_res;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] rem_nxt, quot_nxt, q_fin, r_fin;

  assign accept    = start_i & op_i[2] & ~flush_i;
  assign signed_op = ~op_q[0];
  assign is_rem    = op_q[1];
  assign div_zero  = (dvs_q == '0);
  assign ovf       = signed_op & (dvd_q == {1'b1, {(DATA_W-1){1'b0}}}) & (dvs_q == '1);
  assign last      = (cnt == CNT_W'(DATA_W-1));

  // Signed ops iterate on magnitudes; signs are restored at the end.
  assign neg_q   = signed_op & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
  assign neg_r   = signed_op & dvd_q[DATA_W-1];
  assign dvd_abs = (signed_op & dvd_q[DATA_W-1]) ? -dvd_q : dvd_q;
  assign dvs_abs = (signed_op & dvs_q[DATA_W-1]) ? -dvs_q : dvs_q;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  // rem_sh needs one extra bit since an unsigned divisor can use all DATA_W bits.
  assign rem_sh   = {rem, quot[DATA_W-1]};
  assign ge       = (rem_sh >= {1'b0, dvs_abs});
  assign rem_nxt  = ge ? DATA_W'(rem_sh - {1'b0, dvs_abs}) : rem_sh[DATA_W-1:0];
  assign quot_nxt = {quot[DATA_W-2:0], ge};
  assign q_fin    = neg_q ? -quot_nxt : quot_nxt;
  assign r_fin    = neg_r ? -rem_nxt : rem_nxt;

  assign special_res = div_zero ? (is_rem ? dvd_q : '1)
                                : (is_rem ? '0 : {1'b1, {(DATA_W-1){1'b0}}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush aborts anything not yet in the write-back cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: if (flush_i)              state_nxt = S_IDLE;
               else if (div_zero | ovf)  state_nxt = S_END;
               else                      state_nxt = S_CALC;
      S_CALC:  if (flush_i)   state_nxt = S_IDLE;
               else if (last) state_nxt = S_END;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rd_q     <= '0;
      quot     <= '0;
      rem      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          result_q <= '0;
          if (accept) begin
            op_q  <= op_i[1:0];
            dvd_q <= dividend_i;
            dvs_q <= divisor_i;
            rd_q  <= rd_addr_i;
          end
        end
        S_START: begin
          cnt      <= '0;
          rem      <= '0;
          quot     <= dvd_abs;
          result_q <= (!flush_i && (div_zero || ovf)) ? special_res : '0;
        end
        S_CALC: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 1'b1;
          if (!flush_i && last) result_q <= is_rem ? r_fin : q_fin;
        end
        default: result_q <= '0;
      endcase
    end
  end

  assign busy_o    = (state != S_IDLE);
  assign stall_o   = ((state == S_IDLE) & accept) | (state == S_START) | (state == S_CALC);
  assign ready_o   = (state == S_END);
  assign rd_wen_o  = ready_o;
  assign rd_addr_o = ready_o ? rd_q : 5'd0;
  assign result_o  = result_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: scoreboard bench for ex_div; expected write-backs are queued
// at accept time and compared when ready_o pulses.
module tb_ex_div;
  logic        clk = 0, rst = 1;
  logic        start_i = 0, flush_i = 0;
  logic [2:0]  op_i = 0;
  logic [31:0] dividend_i = 0, divisor_i = 0;
  logic [4:0]  rd_addr_i = 0;
  logic        busy_o, stall_o, ready_o, rd_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [31:0] res; logic [4:0] rd; int lat; int acc; } exp_t;
  exp_t sb[$];

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  ex_div dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o), .ready_o(ready_o),
    .result_o(result_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Scoreboard: every ready_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (sb.size() == 0) chk("unexp_ready", 32'(ready_o), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
        chk("rd_wen", 32'(rd_wen_o), 32'd1);
        chk("stall_end", 32'(stall_o), 32'd0);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Drive one request; optionally queue its expected write-back.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    start_i = 1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1 chk("stall_idle", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    start_i = 0; dividend_i = $urandom; divisor_i = $urandom; rd_addr_i = 5'($urandom);
    if (push) begin
      e.res = exp; e.rd = rd; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin @(posedge clk); n++; end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int lat;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_wen", 32'(rd_wen_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst = 0;

    issue(DIVU, 100, 7, 5'd5, 1, 32'd14, 33);                      drain();
    issue(REM, 32'hFFFF_FFF9, 2, 5'd6, 1, 32'hFFFF_FFFF, 33);      drain();
    issue(DIV, 32'hFFFF_FFF9, 2, 5'd7, 1, 32'hFFFF_FFFD, 33);      drain();
    issue(DIV, 123, 0, 5'd8, 1, 32'hFFFF_FFFF, 1);                 drain();
    issue(REMU, 123, 0, 5'd9, 1, 32'd123, 1);                      drain();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 32'h8000_0000, 1); drain();
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'h0, 1);  drain();

    // Non-M request (op[2]=0) must be ignored.
    @(negedge clk); start_i = 1; op_i = 3'b001; dividend_i = 5; divisor_i = 1;
    @(posedge clk); #1 start_i = 0;
    chk("nonm_busy", 32'(busy_o), 32'd0);

    // Flush at CALC cycle 10, then a fresh DIVU.
    issue(DIVU, 1000, 3, 5'd12, 0, 32'd0, 0);
    repeat (11) @(posedge clk);
    @(negedge clk); flush_i = 1;
    @(posedge clk); #1 flush_i = 0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    issue(DIVU, 9, 3, 5'd13, 1, 32'd3, 33);                        drain();

    // start_i held with changing operands during a busy op.
    issue(DIVU, 100, 7, 5'd14, 1, 32'd14, 33);
    begin
      int n = 0;
      start_i = 1; op_i = DIV; rd_addr_i = 5'd1;
      while (!ready_o && n < 60) begin
        @(negedge clk); dividend_i = $urandom; divisor_i = $urandom | 1; n++;
        #1;
      end
      start_i = 0;
    end
    drain();
    repeat (3) @(posedge clk); #1;
    chk("held_start_idle", 32'(busy_o), 32'd0);

    // Random mix checked against the language-level reference.
    for (int i = 0; i < 10; i++) begin
      rop = 3'b100 | 3'($urandom_range(0, 3));
      ra  = (i == 3) ? 32'h8000_0000 : $urandom;
      rb  = (i == 3) ? 32'hFFFF_FFFF : (i == 5) ? 32'd0 : (i % 2) ? 32'($urandom_range(1, 50)) : $urandom;
      lat = (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33;
      issue(rop, ra, rb, 5'(i + 16), 1, ref_div(rop, ra, rb), lat);
      drain();
    end

    // Reset in CALC cycle 20: everything clears, no write-back.
    issue(DIV, 1000, 7, 5'd15, 0, 32'd0, 0);
    repeat (21) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    chk("mid_rst_result", result_o, 32'd0);
    chk("mid_rst_rd", 32'(rd_addr_o), 32'd0);
    chk("mid_rst_wen", 32'(rd_wen_o), 32'd0);
    @(negedge clk); rst = 0;
    repeat (40) @(posedge clk);
    #1 chk("post_rst_idle", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative multi-cycle divider controller attached to the execute stage. It takes the RV32M DIV/DIVU/REM/REMU operation from ex, along with its operands and destination register.
- Sequences a 32-iteration restoring division and holds the pipeline via a stall request while busy.
- Returns one registered write-back (rd address, data, write-enable) to the regs path when finished.
- Handles divide-by-zero, signed overflow and pipeline flush.

Parameters:
- DATA_W, 32, operand/result width; counter sized log2(DATA_W)+1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start_i  input  1  request from ex, sampled only in IDLE
- op_i  input  3  func3 of the instruction: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
- dividend_i  input  32  op1 (rs1 value)
- divisor_i  input  32  op2 (rs2 value)
- rd_addr_i  input  5  destination register
- flush_i  input  1  pipeline flush (jump/branch taken), aborts operation
- busy_o  output  1  state != IDLE
- stall_o  output  1  hold-pipeline request to ctrl
- ready_o  output  1  one-cycle completion pulse
- result_o  output  32  quotient or remainder; valid only while ready_o
- rd_addr_o  output  5  latched rd; valid only while ready_o
- rd_wen_o  output  1  equals ready_o

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; counter, operand latches, result_o, rd_addr_o, ready_o, rd_wen_o all 0. Reset overrides everything, including mid-CALC.
- States: IDLE, START, CALC, END.
- IDLE:
  - Accept when start_i=1, op_i[2]=1 and flush_i=0.
  - On accept, latch dividend, divisor, op, rd_addr and go to START.
  - A request with op_i[2]=0 is ignored.
- START (1 cycle):
  - divisor==0 → END with the div-by-zero result.
  - op=DIV/REM, dividend==32'h8000_0000 and divisor==32'hFFFF_FFFF → END with the overflow result.
  - Otherwise → CALC with counter=0 and remainder accumulator=0.
  - Signed ops use absolute values; record quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend).
- CALC (exactly 32 cycles):
  - Each cycle: shift {rem,quot} left by 1, bringing in the next dividend MSB.
  - If rem >= |divisor|, subtract it and set quot LSB=1.
  - Counter increments; after count 31 → END.
- END (1 cycle):
  - ready_o=1, rd_wen_o=1.
  - result_o: quotient for DIV/DIVU, remainder for REM/REMU, sign-corrected for signed ops.
  - Next state IDLE.
- Special results:
  - Divide by zero: DIV/DIVU quotient = 32'hFFFF_FFFF; REM/REMU = dividend.
  - Overflow: DIV = 32'h8000_0000; REM = 0.
- Latency (accept edge = E0):
  - Normal: ready_o high in the cycle after E33, i.e. 34 cycles after accept.
  - Special case: ready_o high in the cycle after E1.
- stall_o:
  - High combinationally in IDLE when a valid start_i is present.
  - High throughout START and CALC.
  - Low in END, so the pipeline advances with the write-back.
- Outputs when not ready:
  - result_o is registered and driven 0 outside END.
  - rd_addr_o is 0 outside END.
  - rd_wen_o is 0 outside END.
- Mid-operation inputs:
  - start_i while busy is ignored; no queueing.
  - Operand input changes after accept have no effect.
- flush_i:
  - In START or CALC: next state IDLE, no ready_o pulse, no write.
  - In END: the write still completes, since the instruction has already retired.
  - In IDLE: blocks accept.
- Back-to-back: a new start_i may be accepted in the IDLE cycle immediately after END.

Test Plan:
- DIVU, dividend=100, divisor=7 → ready_o exactly 34 cycles after accept; result_o=14, rd_addr_o=latched rd, rd_wen_o=1 for one cycle.
- REM, dividend=32'hFFFF_FFF9 (-7), divisor=2 → result_o=32'hFFFF_FFFF (-1); DIV on the same operands → 32'hFFFF_FFFD (-3).
- DIV and REMU with divisor=0, dividend=123 → ready 2 cycles after accept; DIV → 32'hFFFF_FFFF, REMU → 123; stall_o low in END.
- DIV with 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000 after 2 cycles; REM → 0.
- flush_i pulsed at CALC cycle 10 → IDLE next cycle, busy_o=0, no ready_o; a following DIVU 9/3 → 3.
- start_i with new operands held high throughout a busy op → ignored; rst=1 asserted at CALC cycle 20 → all outputs 0, state IDLE, no ready pulse.
